// File: rtl/axi_mem_pkg.sv
// Shared encodings and constants for the AXI-Lite memory slave.
package axi_mem_pkg;

  localparam int unsigned DEFAULT_DEPTH = 16;
  localparam logic [31:0] ERR_DATA      = 32'hDEAD_BEEF;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/mem_slave_ram.sv
// DEPTH x 32 storage: one synchronous write port, one registered read port,
// whole array and read register cleared by the asynchronous reset.
module mem_slave_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register only loads on a capture, so the value holds for the whole beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI-Lite word-addressed memory slave with independent read and write FSMs.
// Define ADDR_CHECK_EN to flag out-of-range addresses instead of aliasing them.
module axi_lite_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ARVALID,
  input  logic [31:0] ARADDR,
  output logic        ARREADY,
  output logic        RVALID,
  output logic [31:0] RDATA,
  input  logic        RREADY,
  input  logic        AWVALID,
  input  logic [31:0] AWADDR,
  output logic        AWREADY,
  input  logic        WVALID,
  input  logic [31:0] WDATA,
  output logic        WREADY,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [7:0]  rd_count,
  output logic [7:0]  wr_count,
  output logic        addr_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  rd_state_e     r_rd_state, w_rd_next;
  wr_state_e     r_wr_state, w_wr_next;
  logic [AW-1:0] r_wr_idx;
  logic [7:0]    r_rd_cnt, r_wr_cnt;
  logic [31:0]   w_ram_rdata;
  logic          w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_we;
  logic          w_unused_addr;

  assign w_ar_hs = ARVALID && ARREADY;
  assign w_r_hs  = RVALID  && RREADY;
  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs  = WVALID  && WREADY;
  assign w_b_hs  = BVALID  && BREADY;
  assign w_unused_addr = ^{ARADDR, AWADDR};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_state <= R_IDLE;
      r_wr_state <= W_ADDR;
    end else begin
      r_rd_state <= w_rd_next;
      r_wr_state <= w_wr_next;
    end
  end

  always_comb begin
    w_rd_next = r_rd_state;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) w_rd_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY) w_rd_next = R_IDLE;
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_wr_next = r_wr_state;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    case (r_wr_state)
      W_ADDR: begin
        AWREADY = 1'b1;
        if (AWVALID) w_wr_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID) w_wr_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_wr_next = W_ADDR;
      end
      default: w_wr_next = W_ADDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_idx <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_aw_hs) r_wr_idx <= AWADDR[AW+1:2];
      if (w_r_hs)  r_rd_cnt <= r_rd_cnt + 8'd1;
      if (w_b_hs)  r_wr_cnt <= r_wr_cnt + 8'd1;
    end
  end

  assign rd_count = r_rd_cnt;
  assign wr_count = r_wr_cnt;

`ifdef ADDR_CHECK_EN
  logic w_ar_err, w_aw_err;
  logic r_rd_err, r_wr_err, r_addr_err;

  assign w_ar_err = |ARADDR[31:AW+2];
  assign w_aw_err = |AWADDR[31:AW+2];

  // Error status is captured alongside the address so it tracks the beat it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_err   <= 1'b0;
      r_wr_err   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_ar_hs) r_rd_err <= w_ar_err;
      if (w_aw_hs) r_wr_err <= w_aw_err;
      if ((w_ar_hs && w_ar_err) || (w_aw_hs && w_aw_err)) r_addr_err <= 1'b1;
    end
  end

  assign w_we     = w_w_hs && !r_wr_err;
  assign RDATA    = r_rd_err ? ERR_DATA : w_ram_rdata;
  assign addr_err = r_addr_err;
`else
  assign w_we     = w_w_hs;
  assign RDATA    = w_ram_rdata;
  assign addr_err = 1'b0;
`endif

  mem_slave_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_we   (w_we),
    .i_waddr(r_wr_idx),
    .i_wdata(WDATA),
    .i_re   (w_ar_hs),
    .i_raddr(ARADDR[AW+1:2]),
    .o_rdata(w_ram_rdata)
  );

endmodule
